// File: rtl/pipe_delay_reg_pkg.sv
// rtl/pipe_delay_reg_pkg.sv - shared width constants and helpers for pipe_delay_reg
//
// Purpose : common constants for the delay-line core: default geometry,
//           the fill bit used to build the default RESET_VAL, and the
//           occupancy-counter width helper.
// Ports   : none (package).
package pipe_delay_reg_pkg;

    // Default geometry of a delay line when the instantiator does not override it.
    localparam int PIPE_DEFAULT_WIDTH = 5;
    localparam int PIPE_DEFAULT_DEPTH = 3;

    // Every data bit of every stage comes out of reset at this value.
    localparam bit PIPE_RESET_FILL = 1'b0;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_delay_reg_stage.sv
// rtl/pipe_delay_reg_stage.sv - one pipeline slot: WIDTH data bits plus a valid bit
//
// Purpose : single stage of the delay line with hold (stall) and kill (flush).
// Ports   :
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high; data -> RESET_VAL, valid -> 0
//   hold     in   1      1 = keep current data and valid
//   kill     in   1      1 = valid is 0 after this edge, regardless of hold
//   d        in   WIDTH  data from the upstream slot (or pipe input)
//   d_valid  in   1      valid from the upstream slot (or pipe input)
//   q        out  WIDTH  registered data
//   q_valid  out  1      registered valid
module pipe_stage
    import pipe_delay_reg_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{PIPE_RESET_FILL}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             kill,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] d_mux;
    logic             valid_next;

    // Per-bit recirculating hold mux, the same shape as the enable registers
    // elsewhere in the core. Kill never touches data; consumers qualify with valid.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign d_mux[b] = hold ? q[b] : d[b];
    end

    // Kill is applied last so it overrides both hold and advance.
    assign valid_next = (hold ? q_valid : d_valid) & ~kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else begin
            q       <= d_mux;
            q_valid <= valid_next;
        end
    end

endmodule

// File: rtl/pipe_delay_reg.sv
// rtl/pipe_delay_reg.sv - DEPTH-stage pipeline register with stall, per-stage flush and occupancy count
//
// Purpose : fixed-latency delay line between pipeline stages (writeback tag
//           delay, multi-cycle execute results). An entry accepted with
//           in_valid appears on out after DEPTH non-stalled edges unless a
//           flush kills it on the way.
// Ports   :
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high; clears all state immediately
//   stall        in   1      1 = every stage holds, in/in_valid ignored
//   flush        in   DEPTH  flush[k] = 1 makes stage k invalid after this edge
//   in_valid     in   1      valid entering stage 0
//   in           in   WIDTH  data entering stage 0
//   out          out  WIDTH  data of stage DEPTH-1
//   out_valid    out  1      valid of stage DEPTH-1
//   stage_valid  out  DEPTH  valid bit of every stage, for hazard detection
//   count        out  CNT_W  number of valid stages (registered)
module pipe_delay_reg
    import pipe_delay_reg_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter int               DEPTH     = PIPE_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{PIPE_RESET_FILL}},
    parameter int               CNT_W     = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;

        if (k == 0) begin : g_head
            assign src_data  = in;
            assign src_valid = in_valid;
        end else begin : g_body
            assign src_data  = stage_data[k-1];
            assign src_valid = valid_q[k-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .hold    (stall),
            .kill    (flush[k]),
            .d       (src_data),
            .d_valid (src_valid),
            .q       (stage_data[k]),
            .q_valid (valid_q[k])
        );

        // Valid vector the stages will hold after this edge. The counter is
        // fed from it so count lands on the same edge as stage_valid instead
        // of lagging one cycle behind.
        assign valid_next[k] = (stall ? valid_q[k] : src_valid) & ~flush[k];
    end

    always_comb begin
        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + CNT_W'(valid_next[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign out         = stage_data[DEPTH-1];
    assign out_valid   = valid_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign count       = count_q;

endmodule

// File: tb/tb_pipe_delay_reg.sv
// tb/tb_pipe_delay_reg.sv - self-checking bench for pipe_delay_reg (DEPTH=3 and DEPTH=1)
module tb_pipe_delay_reg;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 2;
    localparam logic [W-1:0] S_RST = 8'h3C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DEPTH = 3 instance
    logic           stall;
    logic [D-1:0]   flush;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [W-1:0]   out;
    logic           out_valid;
    logic [D-1:0]   stage_valid;
    logic [CW-1:0]  count;

    // DEPTH = 1 instance with a non-zero reset value
    logic           s_stall;
    logic [0:0]     s_flush;
    logic           s_in_valid;
    logic [W-1:0]   s_in;
    logic [W-1:0]   s_out;
    logic           s_out_valid;
    logic [0:0]     s_stage_valid;
    logic [0:0]     s_count;

    pipe_delay_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in(in_data), .out(out), .out_valid(out_valid),
        .stage_valid(stage_valid), .count(count)
    );

    pipe_delay_reg #(.WIDTH(W), .DEPTH(1), .RESET_VAL(S_RST)) u_dut1 (
        .clk(clk), .reset(reset), .stall(s_stall), .flush(s_flush),
        .in_valid(s_in_valid), .in(s_in), .out(s_out), .out_valid(s_out_valid),
        .stage_valid(s_stage_valid), .count(s_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          chk_out;
        logic [W-1:0]  out;
        logic          ov;
        logic [D-1:0]  sv;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic          st;
        logic [D-1:0]  fl;
        logic          iv;
        logic [W-1:0]  din;
        logic          chk_out;
        logic [W-1:0]  eout;
        logic          eov;
        logic [D-1:0]  esv;
        logic [CW-1:0] ecnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    // Behavioural reference of the stage array
    logic [W-1:0] m_data [D];
    logic [D-1:0] m_valid;

    task automatic model_edge();
        for (int k = D - 1; k >= 0; k--) begin
            if (!stall) begin
                if (k == 0) begin
                    m_data[k]  = in_data;
                    m_valid[k] = in_valid & ~flush[k];
                end else begin
                    m_data[k]  = m_data[k-1];
                    m_valid[k] = m_valid[k-1] & ~flush[k];
                end
            end else begin
                m_valid[k] = m_valid[k] & ~flush[k];
            end
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.chk_out = 1'b1;
        e.out     = m_data[D-1];
        e.ov      = m_valid[D-1];
        e.sv      = m_valid;
        e.cnt     = CW'($countones(m_valid));
        return e;
    endfunction

    task automatic compare_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sb_empty: got 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_out) check({tag, "_out"}, out, e.out);
            check({tag, "_out_valid"}, out_valid, e.ov);
            check({tag, "_stage_valid"}, stage_valid, e.sv);
            check({tag, "_count"}, count, e.cnt);
        end
    endtask

    // Drive one edge on the DEPTH=3 instance; expectation comes from the
    // table entry or, when use_model is set, from the reference model.
    task automatic drive_step(input string tag, input logic st, input logic [D-1:0] fl,
                              input logic iv, input logic [W-1:0] din,
                              input logic use_model, input exp_t e_tab);
        stall    = st;
        flush    = fl;
        in_valid = iv;
        in_data  = din;
        model_edge();
        if (use_model) sb.push_back(model_expect());
        else           sb.push_back(e_tab);
        @(posedge clk);
        #1;
        compare_sb(tag);
    endtask

    function automatic void add_vec(input logic st, input logic [D-1:0] fl, input logic iv,
                                    input logic [W-1:0] din, input logic chk,
                                    input logic [W-1:0] eout, input logic eov,
                                    input logic [D-1:0] esv, input logic [CW-1:0] ecnt);
        vec_t v;
        v.st = st; v.fl = fl; v.iv = iv; v.din = din;
        v.chk_out = chk; v.eout = eout; v.eov = eov; v.esv = esv; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic step1(input logic st, input logic fl, input logic iv, input logic [W-1:0] din,
                         input logic [W-1:0] eout, input logic eov);
        s_stall    = st;
        s_flush    = fl;
        s_in_valid = iv;
        s_in       = din;
        model_edge();
        @(posedge clk);
        #1;
        check("d1_out", s_out, eout);
        check("d1_out_valid", s_out_valid, eov);
        check("d1_stage_valid", s_stage_valid, eov);
        check("d1_count", s_count, eov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e0;
        e0 = '0;
        for (int k = 0; k < D; k++) m_data[k] = '0;
        m_valid = '0;

        // latency
        add_vec(0, 3'b000, 1, 8'hA5, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 0, 8'h00, 0, 8'h00, 0, 3'b010, 1);
        add_vec(0, 3'b000, 0, 8'h00, 1, 8'hA5, 1, 3'b100, 1);
        add_vec(0, 3'b000, 0, 8'h00, 0, 8'h00, 0, 3'b000, 0);
        // streaming
        add_vec(0, 3'b000, 1, 8'h01, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 1, 8'h02, 0, 8'h00, 0, 3'b011, 2);
        add_vec(0, 3'b000, 1, 8'h03, 1, 8'h01, 1, 3'b111, 3);
        add_vec(0, 3'b000, 1, 8'h04, 1, 8'h02, 1, 3'b111, 3);
        add_vec(0, 3'b000, 0, 8'h00, 1, 8'h03, 1, 3'b110, 2);
        add_vec(0, 3'b000, 0, 8'h00, 1, 8'h04, 1, 3'b100, 1);
        add_vec(0, 3'b000, 0, 8'h00, 0, 8'h00, 0, 3'b000, 0);
        // stall
        add_vec(0, 3'b000, 1, 8'h11, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 1, 8'h22, 0, 8'h00, 0, 3'b011, 2);
        add_vec(0, 3'b000, 1, 8'h33, 1, 8'h11, 1, 3'b111, 3);
        for (int i = 0; i < 4; i++)
            add_vec(1, 3'b000, 1, 8'hFF, 1, 8'h11, 1, 3'b111, 3);
        add_vec(0, 3'b000, 0, 8'h00, 1, 8'h22, 1, 3'b110, 2);
        add_vec(0, 3'b000, 0, 8'h00, 1, 8'h33, 1, 3'b100, 1);
        add_vec(0, 3'b000, 0, 8'h00, 0, 8'h00, 0, 3'b000, 0);
        // middle flush, advancing then stalled
        add_vec(0, 3'b000, 1, 8'h41, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 1, 8'h42, 0, 8'h00, 0, 3'b011, 2);
        add_vec(0, 3'b000, 1, 8'h43, 1, 8'h41, 1, 3'b111, 3);
        add_vec(0, 3'b010, 0, 8'h00, 1, 8'h42, 1, 3'b100, 1);
        add_vec(0, 3'b000, 1, 8'h44, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 1, 8'h45, 0, 8'h00, 0, 3'b011, 2);
        add_vec(0, 3'b000, 1, 8'h46, 1, 8'h44, 1, 3'b111, 3);
        add_vec(1, 3'b010, 0, 8'h00, 1, 8'h44, 1, 3'b101, 2);
        // flush-all with stall and new input, then refill
        add_vec(1, 3'b111, 1, 8'h77, 0, 8'h00, 0, 3'b000, 0);
        add_vec(0, 3'b000, 1, 8'h5A, 0, 8'h00, 0, 3'b001, 1);
        add_vec(0, 3'b000, 1, 8'h5B, 0, 8'h00, 0, 3'b011, 2);
        // flush-all while advancing discards the incoming entry too
        add_vec(0, 3'b111, 1, 8'h5C, 0, 8'h00, 0, 3'b000, 0);
        add_vec(0, 3'b000, 0, 8'h00, 0, 8'h00, 0, 3'b000, 0);

        reset      = 1'b0;
        stall      = 1'b0;
        flush      = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        s_stall    = 1'b0;
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        s_in       = '0;

        // asynchronous reset assertion, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_out", out, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_stage_valid", stage_valid, 3'b000);
        check("rst_count", count, 2'd0);
        check("rst_d1_out", s_out, S_RST);
        check("rst_d1_out_valid", s_out_valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            e.chk_out = vecs[i].chk_out;
            e.out     = vecs[i].eout;
            e.ov      = vecs[i].eov;
            e.sv      = vecs[i].esv;
            e.cnt     = vecs[i].ecnt;
            drive_step($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].iv,
                       vecs[i].din, 1'b0, e);
        end

        // constrained-random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            logic          st;
            logic [D-1:0]  fl;
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(5) == 0) ? D'($urandom_range(7)) : '0;
            drive_step($sformatf("rnd%0d", i), st, fl, 1'($urandom_range(1)),
                       W'($urandom), 1'b1, e0);
        end

        // DEPTH = 1: one-edge latency, bubble, flush, stall; main pipe holds
        stall = 1'b1;
        flush = '0;
        step1(0, 0, 1, 8'h11, 8'h11, 1);
        step1(0, 0, 1, 8'h22, 8'h22, 1);
        step1(1, 0, 1, 8'h33, 8'h22, 1);
        step1(0, 0, 0, 8'h44, 8'h44, 0);
        step1(0, 1, 1, 8'h55, 8'h55, 0);
        step1(0, 0, 1, 8'hE7, 8'hE7, 1);
        step1(1, 1, 1, 8'hF0, 8'hE7, 0);
        step1(0, 0, 1, 8'h69, 8'h69, 1);

        // fill the main pipe, then reset asynchronously during stall + flush
        for (int i = 0; i < D; i++)
            drive_step($sformatf("fill%0d", i), 1'b0, '0, 1'b1, W'(8'hC0 + i), 1'b1, e0);
        check("full_count", count, 2'd3);
        stall    = 1'b1;
        flush    = 3'b010;
        in_valid = 1'b1;
        s_stall  = 1'b1;
        s_flush  = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_out", out, 8'h00);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_stage_valid", stage_valid, 3'b000);
        check("arst_count", count, 2'd0);
        check("arst_d1_out", s_out, S_RST);
        check("arst_d1_count", s_count, 1'b0);
        #2 reset = 1'b0;
        for (int k = 0; k < D; k++) m_data[k] = '0;
        m_valid = '0;
        s_stall = 1'b0;
        s_flush = 1'b0;

        // first edges after release are ordinary advances
        drive_step("post_rst0", 1'b0, '0, 1'b1, 8'h99, 1'b1, e0);
        drive_step("post_rst1", 1'b0, '0, 1'b0, 8'h00, 1'b1, e0);
        drive_step("post_rst2", 1'b0, '0, 1'b0, 8'h00, 1'b1, e0);
        check("post_rst_out", out, 8'h99);
        check("d1_post_rst_out", s_out, 8'h69);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
